// File: rtl/axi_mm_chk_seq.sv
// axi_mm_chk_seq: arms the AXI-MM pattern checker, launches patgen, tallies verdicts.
// Optional: AXI_MM_CHK_SEQ_STOP_ON_FAIL_EN ends the session on the first failed run.

module axi_mm_chk_seq #(
  parameter int RUN_W      = 8,
  parameter int TMO_W      = 16,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 8
) (
  input  logic             rdclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [RUN_W-1:0] num_runs,
  input  logic [7:0]       burst_len,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic [1:0]       patchkr_out,
  input  logic             chkr_fifo_full,
  output logic             patchkr_en,
  output logic             cntuspatt_en,
  output logic [7:0]       patgen_cnt,
  output logic             patgen_go,
  output logic             busy,
  output logic             done,
  output logic [RUN_W-1:0] pass_cnt,
  output logic [RUN_W-1:0] fail_cnt,
  output logic             tmo_err,
  output logic             ovf_err
);

`ifdef AXI_MM_CHK_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int CMAX  = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_RECORD,
    S_GAP,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic             r_start;
  logic             r_cont;
  logic             r_cus;
  logic             r_tmo_err;
  logic             r_ovf;
  logic [RUN_W-1:0] r_nruns;
  logic [RUN_W-1:0] r_idx;
  logic [RUN_W-1:0] r_pass;
  logic [RUN_W-1:0] r_fail;
  logic [7:0]       r_burst;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo;

  logic             w_go;
  logic             w_wait;
  logic             w_tmo_hit;
  logic             w_pass;
  logic             w_fail;
  logic             w_tmo;
  logic             w_last;
  logic [TMO_W:0]   w_tmo_nx;
  logic [RUN_W-1:0] w_idx_nx;

  assign w_go      = start & ~r_start;
  assign w_wait    = (r_state == S_WAIT) & ~abort;
  assign w_tmo_nx  = {1'b0, r_tmo} + (TMO_W+1)'(1);
  assign w_tmo_hit = (tmo_limit != '0) &&
                     (w_tmo_nx >= {1'b0, tmo_limit});
  // A verdict in the timeout cycle takes precedence.
  assign w_pass    = w_wait & (patchkr_out == 2'b11);
  assign w_fail    = w_wait & (patchkr_out == 2'b10);
  assign w_tmo     = w_wait & ~w_pass & ~w_fail & w_tmo_hit;
  assign w_idx_nx  = r_idx + RUN_W'(1);
  assign w_last    = (w_idx_nx == r_nruns);

  assign cntuspatt_en = r_cus;
  assign patgen_cnt   = busy ? r_burst : 8'd0;
  assign pass_cnt     = r_pass;
  assign fail_cnt     = r_fail;
  assign tmo_err      = r_tmo_err;
  assign ovf_err      = r_ovf;

  always_comb begin
    w_nstate   = r_state;
    patchkr_en = 1'b0;
    patgen_go  = 1'b0;
    done       = 1'b0;
    busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    if (abort && busy) begin
      w_nstate = S_FIN;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_go) w_nstate = S_ARM;
        S_ARM:    w_nstate = S_SETTLE;
        // ARM itself counts, so launch lands SETTLE_CYC after arm
        S_SETTLE: if (r_cnt == CNT_W'(SETTLE_CYC - 2))
                    w_nstate = S_LAUNCH;
        S_LAUNCH: w_nstate = S_WAIT;
        S_WAIT: begin
          if (w_pass)
            w_nstate = S_RECORD;
          else if (w_fail || w_tmo)
            w_nstate = STOP_ON_FAIL ? S_FIN : S_RECORD;
        end
        S_RECORD: w_nstate = w_last ? S_FIN : S_GAP;
        S_GAP:    if (r_cnt == CNT_W'(GAP_CYC - 1))
                    w_nstate = S_ARM;
        S_FIN:    w_nstate = S_IDLE;
        default:  w_nstate = S_IDLE;
      endcase
    end
    if (r_state == S_ARM) patchkr_en = ~r_cont;
    if (r_state == S_LAUNCH) patgen_go = 1'b1;
    if (r_state == S_FIN) done = 1'b1;
  end

  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b0;
      r_cont    <= 1'b0;
      r_cus     <= 1'b0;
      r_tmo_err <= 1'b0;
      r_ovf     <= 1'b0;
      r_nruns   <= '0;
      r_idx     <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
    end else begin
      r_state <= w_nstate;
      r_start <= start;
      if (r_state == S_IDLE && w_go) begin
        r_cont    <= cont_mode;
        r_cus     <= cont_mode;
        r_nruns   <= (num_runs == '0) ? RUN_W'(1) : num_runs;
        r_burst   <= burst_len;
        r_idx     <= '0;
        r_pass    <= '0;
        r_fail    <= '0;
        r_tmo_err <= 1'b0;
        r_ovf     <= 1'b0;
      end
      if (r_state == S_ARM || r_state == S_RECORD)
        r_cnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_GAP)
        r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_RECORD)
        r_idx <= w_idx_nx;
      if (r_state == S_LAUNCH)
        r_tmo <= '0;
      else if (r_state == S_WAIT && r_tmo != '1)
        r_tmo <= r_tmo + TMO_W'(1);
      if (w_pass && r_pass != '1)
        r_pass <= r_pass + RUN_W'(1);
      if ((w_fail || w_tmo) && r_fail != '1)
        r_fail <= r_fail + RUN_W'(1);
      if (w_tmo)
        r_tmo_err <= 1'b1;
      if ((r_state == S_LAUNCH || r_state == S_WAIT) &&
          chkr_fifo_full)
        r_ovf <= 1'b1;
      if (r_state == S_FIN)
        r_cus <= 1'b0;
    end
  end

endmodule
